// File: rtl/alu_exec_unit.sv
// EX-stage ALU: RV32I ALU/branch decode + execute, with an iterative
// M-extension multiply/divide unit that stalls the pipe via busy/in_ready.
//
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   in_valid/in_ready  operation handshake (in_ready = !busy)
//   alu_op, funct7,
//   funct3             decode inputs
//   op_a, op_b         rs1 / rs2-or-immediate operands
//   flush              drop presented op, abort in-flight MDU op
//   out_valid          one-cycle pulse: result/flags valid
//   result             result, held between pulses
//   branch_taken       compare outcome for alu_op=01
//   illegal_op         undecodable combination
//   busy               iterative op in flight
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit EN_MDU = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal_op,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE, LOAD, ITER, FIX
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT,
    OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_BR, OP_MDU,
    OP_ILL
  } op_t;

  function automatic op_t base_op(
    input logic [2:0] f3
  );
    op_t o;
    unique case (f3)
      3'b000:  o = OP_ADD;
      3'b001:  o = OP_SLL;
      3'b010:  o = OP_SLT;
      3'b011:  o = OP_SLTU;
      3'b100:  o = OP_XOR;
      3'b101:  o = OP_SRL;
      3'b110:  o = OP_OR;
      default: o = OP_AND;
    endcase
    return o;
  endfunction

  state_t state_q, state_d;
  op_t    op;

  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            taken;
  logic [SW-1:0]   shamt;

  // MDU datapath
  logic [2:0]      kind;
  logic [XLEN-1:0] a_raw, b_raw;
  logic [XLEN-1:0] hi, lo, m;
  logic [SW-1:0]   cnt;
  logic            neg_p, neg_r, b_zero;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_r, div_d;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo, rem, mdu_res;

  assign busy     = (state_q != IDLE);
  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready & ~flush;
  assign shamt    = op_b[SW-1:0];

  always_comb begin
    op = OP_ILL;
    unique case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: begin
        if (funct3[2:1] != 2'b01)
          op = OP_BR;
      end
      2'b10: begin
        unique case (funct7)
          7'b0000000: op = base_op(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)
              op = OP_SUB;
            else if (funct3 == 3'b101)
              op = OP_SRA;
          end
          7'b0000001: begin
            if (EN_MDU)
              op = OP_MDU;
          end
          default: op = OP_ILL;
        endcase
      end
      default: begin
        op = base_op(funct3);
        if (funct3 == 3'b001 &&
            funct7 != 7'b0000000)
          op = OP_ILL;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000)
            op = OP_SRL;
          else if (funct7 == 7'b0100000)
            op = OP_SRA;
          else
            op = OP_ILL;
        end
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB,
      OP_BR:   alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                 $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}},
                 op_a < op_b};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    logic eq, lt, ltu;
    eq    = (op_a == op_b);
    lt    = $signed(op_a) < $signed(op_b);
    ltu   = op_a < op_b;
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
    if (op != OP_BR)
      taken = 1'b0;
  end

  // Operand signedness by funct3: MULHU, DIVU, REMU unsigned;
  // MULHSU has only rs1 signed.
  assign a_sgn = ~(kind[0] & (kind[1] | kind[2]));
  assign b_sgn = a_sgn & (kind != 3'b010);
  assign a_neg = a_sgn & a_raw[XLEN-1];
  assign b_neg = b_sgn & b_raw[XLEN-1];
  assign a_mag = a_neg ? -a_raw : a_raw;
  assign b_mag = b_neg ? -b_raw : b_raw;

  // Multiply: {hi,lo} shifts right, lo holds the multiplier.
  // Divide: hi is the partial remainder, lo the dividend/quotient.
  assign mul_sum = {1'b0, hi} +
                   (lo[0] ? {1'b0, m} : '0);
  assign div_r   = {hi, lo[XLEN-1]};
  assign div_d   = div_r - {1'b0, m};

  assign prod     = {hi, lo};
  assign prod_fix = neg_p ? -prod : prod;
  assign quo      = b_zero ? '1 :
                    (neg_p ? -lo : lo);
  assign rem      = neg_r ? -hi : hi;

  always_comb begin
    mdu_res = rem;
    unique case (kind)
      3'b000:  mdu_res = prod_fix[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  mdu_res = prod_fix[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  mdu_res = quo;
      default: mdu_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && op == OP_MDU)
          state_d = LOAD;
      end
      LOAD: state_d = ITER;
      ITER: begin
        if (cnt == '0)
          state_d = FIX;
      end
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind   <= '0;
      a_raw  <= '0;
      b_raw  <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      cnt    <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            kind  <= funct3;
            a_raw <= op_a;
            b_raw <= op_b;
          end
        end
        LOAD: begin
          neg_p  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          b_zero <= (b_raw == '0);
          hi     <= '0;
          lo     <= kind[2] ? a_mag : b_mag;
          m      <= kind[2] ? b_mag : a_mag;
          cnt    <= SW'(XLEN-1);
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (!kind[2]) begin
            {hi, lo} <= {mul_sum,
                         lo[XLEN-1:1]};
          end else if (!div_d[XLEN]) begin
            hi <= div_d[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= div_r[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      if (accept && op != OP_MDU) begin
        out_valid    <= 1'b1;
        result       <= alu_res;
        branch_taken <= taken;
        illegal_op   <= (op == OP_ILL);
      end else if (state_q == FIX &&
                   !flush) begin
        out_valid <= 1'b1;
        result    <= mdu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed and random ops checked through an
// expected-response queue against a behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid2 = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;

  logic        in_ready, out_valid, branch_taken;
  logic        illegal_op, busy;
  logic [31:0] result;

  logic        in_ready2, out_valid2, taken2;
  logic        illegal2, busy2;
  logic [31:0] result2;

  typedef struct {
    logic [31:0] res;
    logic        tk;
    logic        ill;
    longint      at;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  int     nchk = 0;
  int     nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_unit #(.XLEN(32), .EN_MDU(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7),
    .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .out_valid(out_valid),
    .result(result),
    .branch_taken(branch_taken),
    .illegal_op(illegal_op), .busy(busy)
  );

  alu_exec_unit #(.XLEN(32), .EN_MDU(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_op(alu_op), .funct7(funct7),
    .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(1'b0), .out_valid(out_valid2),
    .result(result2),
    .branch_taken(taken2),
    .illegal_op(illegal2), .busy(busy2)
  );

  task automatic chk(input string name,
                     input longint act,
                     input longint req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h t=%0t",
               name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] basic(
    input logic [2:0] f3, input bit alt,
    input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: return (a < b) ? 1 : 0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh)
                       : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] mext(
    input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] as_, bs_, bu_;
    logic [63:0] p;
    as_ = {{32{a[31]}}, a};
    bs_ = {{32{b[31]}}, b};
    bu_ = {32'b0, b};
    case (f3)
      3'd0: begin p = as_ * bs_; return p[31:0]; end
      3'd1: begin p = as_ * bs_; return p[63:32]; end
      3'd2: begin p = as_ * bu_; return p[63:32]; end
      3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t model(
    input logic [1:0] o, input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = 0; e.tk = 0; e.ill = 0; e.at = 0;
    if (o == 0) begin
      e.res = a + b;
    end else if (o == 1) begin
      if (f3 == 2 || f3 == 3) e.ill = 1;
      else begin
        e.res = a - b;
        case (f3)
          3'd0: e.tk = (a == b);
          3'd1: e.tk = (a != b);
          3'd4: e.tk = ($signed(a) < $signed(b));
          3'd5: e.tk = ($signed(a) >= $signed(b));
          3'd6: e.tk = (a < b);
          default: e.tk = (a >= b);
        endcase
      end
    end else if (o == 2 && f7 == 7'h01) begin
      e.res = mext(f3, a, b);
    end else if ((o == 2 && f7 == 0) ||
                 (o == 3 && (f7 == 0 ||
                  (f3 != 1 && f3 != 5)))) begin
      e.res = basic(f3, 0, a, b);
    end else if (f7 == 7'h20 &&
                 (f3 == 5 || (o == 2 && f3 == 0))) begin
      e.res = basic(f3, 1, a, b);
    end else begin
      e.ill = 1;
    end
    return e;
  endfunction

  task automatic drive(
    input logic [1:0] o, input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b,
    input bit push, input exp_t e);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready)
      chk("ready_timeout", 0, 1);
    alu_op = o; funct7 = f7; funct3 = f3;
    op_a = a; op_b = b; in_valid = 1'b1;
    if (push) begin
      e.at = cyc + 1 +
        ((o == 2 && f7 == 7'h01) ? 34 : 0);
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(
    input logic [1:0] o, input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    drive(o, f7, f3, a, b, 1, model(o, f7, f3, a, b));
  endtask

  task automatic send_k(
    input logic [1:0] o, input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] r, input logic tk,
    input logic il);
    exp_t e;
    e.res = r; e.tk = tk; e.ill = il; e.at = 0;
    drive(o, f7, f3, a, b, 1, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && !out_valid && cyc > q[0].at) begin
        chk("missing_out_valid", 0, 1);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("branch_taken", branch_taken, e.tk);
          chk("illegal_op", illegal_op, e.ill);
          chk("latency_cycle", cyc, e.at);
        end
      end
    end
  end

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] sp [5];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF,
           32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0)
      return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    exp_t none;
    int n, bad;
    logic [31:0] held;
    logic [6:0] f7;
    none.res = 0; none.tk = 0;
    none.ill = 0; none.at = 0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {branch_taken, illegal_op}, 0);
    rst = 1'b0;
    @(negedge clk);

    send_k(2'b10, 7'h20, 3'b000, 5, 7,
           32'hFFFF_FFFE, 0, 0);
    send_k(2'b11, 7'h20, 3'b101, 32'h8000_0000, 4,
           32'hF800_0000, 0, 0);
    send_k(2'b01, 7'h00, 3'b100, 32'hFFFF_FFFF, 1,
           32'hFFFF_FFFE, 1, 0);
    send_k(2'b01, 7'h00, 3'b110, 32'hFFFF_FFFF, 1,
           32'hFFFF_FFFE, 0, 0);
    send_k(2'b01, 7'h00, 3'b010, 32'hFFFF_FFFF, 1,
           0, 0, 1);
    send_k(2'b11, 7'h20, 3'b001, 3, 1, 0, 0, 1);

    send_k(2'b10, 7'h01, 3'b001, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'h0, 0, 0);
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (in_ready !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    chk("mulh_busy_cycles", n, 34);
    chk("ready_low_while_busy", bad, 0);
    send_k(2'b10, 7'h01, 3'b011, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);

    send_k(2'b10, 7'h01, 3'b100, 7, 32'hFFFF_FFFE,
           32'hFFFF_FFFD, 0, 0);
    send_k(2'b10, 7'h01, 3'b110, 7, 32'hFFFF_FFFE,
           1, 0, 0);
    send_k(2'b10, 7'h01, 3'b101, 32'h1234, 0,
           32'hFFFF_FFFF, 0, 0);
    send_k(2'b10, 7'h01, 3'b110, 32'h8000_0000,
           32'hFFFF_FFFF, 0, 0, 0);
    send_k(2'b10, 7'h01, 3'b100, 32'h8000_0000,
           32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    send_k(2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 0,
           32'hFFFF_FFFF, 0, 0);
    send_k(2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 0,
           32'hFFFF_FFF9, 0, 0);
    while (busy) @(negedge clk);

    // Flush an in-flight DIVU partway through iterating.
    held = result;
    drive(2'b10, 7'h01, 3'b101, 32'hFFFF, 3, 0, none);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("flush_result_held", result, held);

    // in_valid together with flush must not be accepted.
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b000;
    op_a = 3; op_b = 4;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_busy", busy, 0);
    chk("flush_accept_out_valid", out_valid, 0);

    // Reset in the middle of a multiply.
    send_k(2'b00, 7'h00, 3'b000, 32'h10, 32'h20,
           32'h30, 0, 0);
    drive(2'b10, 7'h01, 3'b000, 9, 9, 0, none);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_result", result, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // EN_MDU=0 build flags M-extension encodings illegal.
    alu_op = 2'b00; funct7 = 7'h00; funct3 = 3'b000;
    op_a = 32'h40; op_b = 32'h2;
    in_valid2 = 1'b1;
    @(negedge clk);
    chk("nomdu_add_result", result2, 32'h42);
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b000;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("nomdu_out_valid", out_valid2, 1);
    chk("nomdu_illegal", illegal2, 1);
    chk("nomdu_result", result2, 0);
    chk("nomdu_busy", busy2, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: f7 = 7'h00;
        3, 4:    f7 = 7'h20;
        5, 6:    f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      send(2'($urandom_range(0, 3)), f7,
           3'($urandom_range(0, 7)),
           rnd_opnd(), rnd_opnd());
      if ($urandom_range(0, 4) == 0)
        @(negedge clk);
    end

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
